// File: rtl/offset_adder_seq.sv
// Byte-serial base+offset adder with early termination of upper bytes.
// Ports: i_Clk, i_Reset, i_Start, i_Base, i_Offset, i_Mode -> o_Busy, o_Done, o_Result, o_Flags{Z,N,H,C}.
module offset_adder_seq #(
  parameter int WIDTH = 16,
  parameter int OFF_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_Base,
  input  logic [OFF_W-1:0] i_Offset,
  input  logic [1:0]       i_Mode,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Result,
  output logic [3:0]       o_Flags
);

  localparam int NB = WIDTH / 8;
  localparam int NO = OFF_W / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);
  localparam logic [KW-1:0] K_MIN  = KW'(NO - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BYTE = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_op;
  logic             r_carry;
  logic             r_sign;
  logic             r_sub;
  logic [KW-1:0]    r_k;
  logic             r_h;
  logic             r_c;

  logic             w_accept;
  logic             w_sub;
  logic [WIDTH-1:0] w_ext;
  logic [WIDTH-1:0] w_opnd;
  logic [7:0]       w_a;
  logic [7:0]       w_b;
  logic [8:0]       w_sum;
  logic             w_first;
  logic             w_h;
  logic             w_c;
  logic             w_fin;
  logic [WIDTH-1:0] w_work_nx;

  assign o_Busy = (r_state == S_BYTE);
  assign o_Done = (r_state == S_DONE);

  assign w_accept = i_Start && (r_state != S_BYTE);
  assign w_sub    = (i_Mode == 2'b10);
  assign w_ext    = (i_Mode == 2'b01) ? WIDTH'(i_Offset)
                                      : WIDTH'($signed(i_Offset));
  // Subtract is add of the one's complement with carry-in 1.
  assign w_opnd   = w_sub ? ~w_ext : w_ext;

  assign w_a   = r_work[{r_k, 3'b000} +: 8];
  assign w_b   = r_op[{r_k, 3'b000} +: 8];
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {8'd0, r_carry};

  // Carry into bit 4 recovered from the sum bit.
  assign w_first = (r_k == '0);
  assign w_h = w_first ? (w_sum[4] ^ w_a[4] ^ w_b[4] ^ r_sub) : r_h;
  assign w_c = w_first ? (w_sum[8] ^ r_sub) : r_c;

  // Once the offset bytes are consumed, a carry equal to the operand
  // sign means the remaining bytes add 0 (or FF+1) and stay unchanged.
  assign w_fin = (r_k == K_LAST) ||
                 (((r_k == K_MIN) || (r_k > K_MIN)) &&
                  (w_sum[8] == r_sign));

  always_comb begin
    w_work_nx = r_work;
    w_work_nx[{r_k, 3'b000} +: 8] = w_sum[7:0];
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_op     <= '0;
      r_carry  <= 1'b0;
      r_sign   <= 1'b0;
      r_sub    <= 1'b0;
      r_k      <= '0;
      r_h      <= 1'b0;
      r_c      <= 1'b0;
      o_Result <= '0;
      o_Flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_work  <= i_Base;
            r_op    <= w_opnd;
            r_carry <= w_sub;
            r_sign  <= w_opnd[WIDTH-1];
            r_sub   <= w_sub;
            r_k     <= '0;
            r_state <= S_BYTE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BYTE: begin
          r_work  <= w_work_nx;
          r_carry <= w_sum[8];
          r_h     <= w_h;
          r_c     <= w_c;
          if (w_fin) begin
            r_state  <= S_DONE;
            o_Result <= w_work_nx;
            o_Flags  <= {1'b0, r_sub, w_h, w_c};
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_offset_adder_seq.sv
// Directed-vector bench for offset_adder_seq (16/8 and 32/16 builds).
// Checks latency, results, flags, handshake and reset behaviour.
module tb_offset_adder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;

  logic        st16 = 1'b0;
  logic [15:0] base16 = '0;
  logic [7:0]  off16 = '0;
  logic        busy16, done16;
  logic [15:0] res16;
  logic [3:0]  flg16;

  logic        st32 = 1'b0;
  logic [31:0] base32 = '0;
  logic [15:0] off32 = '0;
  logic        busy32, done32;
  logic [31:0] res32;
  logic [3:0]  flg32;

  logic        sel = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  offset_adder_seq #(.WIDTH(16), .OFF_W(8)) u_dut16 (
    .i_Clk(clk), .i_Reset(rst), .i_Start(st16),
    .i_Base(base16), .i_Offset(off16), .i_Mode(mode),
    .o_Busy(busy16), .o_Done(done16),
    .o_Result(res16), .o_Flags(flg16)
  );

  offset_adder_seq #(.WIDTH(32), .OFF_W(16)) u_dut32 (
    .i_Clk(clk), .i_Reset(rst), .i_Start(st32),
    .i_Base(base32), .i_Offset(off32), .i_Mode(mode),
    .o_Busy(busy32), .o_Done(done32),
    .o_Result(res32), .o_Flags(flg32)
  );

  logic        o_busy, o_done;
  logic [31:0] o_res;
  logic [3:0]  o_flg;

  assign o_busy = sel ? busy32 : busy16;
  assign o_done = sel ? done32 : done16;
  assign o_res  = sel ? res32 : {16'h0, res16};
  assign o_flg  = sel ? flg32 : flg16;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit s, input logic [31:0] b,
                     input logic [15:0] o, input logic [1:0] m,
                     input logic [31:0] er, input logic [3:0] ef,
                     input int p, input string tag);
    @(negedge clk);
    sel  = s;
    mode = m;
    if (s) begin
      base32 = b; off32 = o; st32 = 1'b1;
    end else begin
      base16 = b[15:0]; off16 = o[7:0]; st16 = 1'b1;
    end
    @(posedge clk); #1;
    st16 = 1'b0;
    st32 = 1'b0;
    chk({tag, " busy"}, {31'd0, o_busy}, 32'd1);
    repeat (p - 1) @(posedge clk);
    #1;
    chk({tag, " early"}, {31'd0, o_done}, 32'd0);
    @(posedge clk); #1;
    chk({tag, " done"}, {31'd0, o_done}, 32'd1);
    chk({tag, " idle"}, {31'd0, o_busy}, 32'd0);
    chk({tag, " res"}, o_res, er);
    chk({tag, " flg"}, {28'd0, o_flg}, {28'd0, ef});
    @(posedge clk); #1;
    chk({tag, " pulse"}, {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, busy16}, 32'd0);
    chk("rst done", {31'd0, done16}, 32'd0);
    chk("rst res", {16'd0, res16}, 32'd0);
    chk("rst flg", {28'd0, flg16}, 32'd0);
    chk("rst res32", res32, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 32'hFFF8, 16'h08, 2'b00, 32'h0000, 4'b0011, 2, "carry");
    run(0, 32'h1234, 16'h01, 2'b00, 32'h1235, 4'b0000, 1, "early+");
    run(0, 32'h1201, 16'hFF, 2'b00, 32'h1200, 4'b0011, 1, "early-");
    run(0, 32'h1200, 16'hFF, 2'b00, 32'h11FF, 4'b0000, 2, "neg2");
    run(0, 32'h1000, 16'h01, 2'b10, 32'h0FFF, 4'b0111, 2, "sub");
    run(0, 32'h1000, 16'hFF, 2'b10, 32'h1001, 4'b0111, 1, "subneg");
    run(0, 32'h1234, 16'hFF, 2'b01, 32'h1333, 4'b0011, 2, "zext");
    run(0, 32'h0001, 16'h80, 2'b11, 32'hFF81, 4'b0000, 2, "mode11");

    // Start held through BYTE, then still high in DONE.
    @(negedge clk);
    sel = 1'b0; mode = 2'b00;
    base16 = 16'h1200; off16 = 8'hFF; st16 = 1'b1;
    @(posedge clk); #1;
    base16 = 16'hFFF8; off16 = 8'h08;
    chk("hs busy1", {31'd0, busy16}, 32'd1);
    chk("hs hold1", {16'd0, res16}, 32'hFF81);
    @(posedge clk); #1;
    chk("hs busy2", {31'd0, busy16}, 32'd1);
    chk("hs hold2", {16'd0, res16}, 32'hFF81);
    @(posedge clk); #1;
    chk("hs done1", {31'd0, done16}, 32'd1);
    chk("hs res1", {16'd0, res16}, 32'h11FF);
    chk("hs flg1", {28'd0, flg16}, 32'd0);
    @(posedge clk); #1;
    st16 = 1'b0;
    chk("hs b2b", {31'd0, busy16}, 32'd1);
    chk("hs b2bd", {31'd0, done16}, 32'd0);
    @(posedge clk); #1;
    chk("hs wait", {31'd0, done16}, 32'd0);
    @(posedge clk); #1;
    chk("hs done2", {31'd0, done16}, 32'd1);
    chk("hs res2", {16'd0, res16}, 32'h0000);
    chk("hs flg2", {28'd0, flg16}, 32'd3);

    // Reset in cycle T+1 of a two-byte request.
    @(negedge clk);
    base16 = 16'h1200; off16 = 8'hFF; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr busy", {31'd0, busy16}, 32'd0);
    chk("mr done", {31'd0, done16}, 32'd0);
    chk("mr res", {16'd0, res16}, 32'd0);
    chk("mr flg", {28'd0, flg16}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mr nodone", {31'd0, done16}, 32'd0);
    end
    run(0, 32'hFFF8, 16'h08, 2'b00, 32'h0000, 4'b0011, 2, "after");

    run(1, 32'h0000FFFF, 16'h0001, 2'b01, 32'h00010000, 4'b0011, 3, "w32");
    run(1, 32'hAB00FFFF, 16'h0001, 2'b01, 32'hAB010000, 4'b0011, 3, "w32top");
    run(1, 32'h12345678, 16'hFFFF, 2'b00, 32'h12345677, 4'b0011, 2, "w32neg");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/offset_adder_seq.md
OFFSET_ADDER_SEQ -- requirements
Module: offset_adder_seq

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the base/result width in bits; legal values are multiples of 8 and at least 16.
REQ-002 The block SHALL have parameter OFF_W, default 8, meaning the offset width in bits; legal values are multiples of 8 and at most WIDTH. Derived constants: NB = WIDTH/8 and NO = OFF_W/8.

Interface
REQ-003 i_Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_Reset  input  1  asynchronous, active-high reset.
REQ-005 i_Start  input  1  request strobe, sampled on the rising edge.
REQ-006 i_Base  input  WIDTH  base operand (SP/PC/HL-style address).
REQ-007 i_Offset  input  OFF_W  offset operand.
REQ-008 i_Mode  input  2  operation select:
- 00 = Base + sign-extended offset.
- 01 = Base + zero-extended offset.
- 10 = Base − sign-extended offset.
- 11 = treated as 00.
REQ-009 o_Busy  output  1  high while bytes are being processed.
REQ-010 o_Done  output  1  one-cycle pulse when the result is valid.
REQ-011 o_Result  output  WIDTH  result register.
REQ-012 o_Flags  output  4  {Z, N, H, C}.

Function
REQ-013 The block SHALL compute one byte per clock using an 8-bit add with carry, low byte first (byte 0 = bits 7:0).
REQ-014 Operand preparation:
- Define E = the offset extended to WIDTH (sign-extended for modes 00/10, zero-extended for 01).
- Add modes: operand = E, initial carry-in 0.
- Mode 10: operand = ~E, initial carry-in 1.
- Sign S = the MSB of the operand.
REQ-015 States SHALL be IDLE, BYTE, DONE; the block leaves reset in IDLE.
REQ-016 A request SHALL be accepted when i_Start=1 and o_Busy=0 (state IDLE or DONE). On acceptance the block captures i_Base, i_Offset and i_Mode, sets byte index k=0, and goes to BYTE.
REQ-017 i_Start while o_Busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-018 In BYTE, each cycle SHALL process byte k with the carry from byte k−1. After processing byte k:
- If k = NB−1, go to DONE.
- Else if k ≥ NO−1 and carry-out == S, go to DONE (early termination: the remaining upper bytes are copied unchanged).
- Otherwise k increments and the block stays in BYTE.
REQ-019 o_Busy SHALL equal 1 exactly while in BYTE.
REQ-020 Latency: with acceptance in cycle T and P bytes processed (NO ≤ P ≤ NB), o_Done=1 in cycle T+1+P for exactly one cycle; DONE then returns to IDLE unless a new request is accepted in that cycle.
REQ-021 o_Result and o_Flags SHALL update only on the edge entering DONE, and SHALL hold until the next DONE or reset.
REQ-022 H and C SHALL come from byte 0 only:
- Add modes: H = carry out of bit 3, C = carry out of bit 7.
- Mode 10: H and C are the inverted carries (borrows).
REQ-023 Z SHALL be 0 always. N SHALL be 1 in mode 10 and 0 otherwise.
REQ-024 Results SHALL wrap modulo 2^WIDTH; no overflow indication is produced.

Reset
REQ-025 While i_Reset=1, regardless of state (including mid-operation):
- The state is forced to IDLE.
- o_Busy=0, o_Done=0, o_Result=0, o_Flags=0.
- Any in-flight operation is discarded, with no o_Done afterwards.
REQ-026 The first request SHALL be acceptable in the first clock edge after i_Reset falls.

Verification (WIDTH=16, OFF_W=8 unless stated)
REQ-027 Carry into high byte: Base 0xFFF8, Off 0x08, mode 00 -> Result 0x0000, Flags 0011, P=2, o_Done at T+3.
REQ-028 Early termination, positive and negative offsets:
- Base 0x1234, Off 0x01, mode 00 -> 0x1235, Flags 0000, P=1, o_Done at T+2.
- Base 0x1201, Off 0xFF -> 0x1200, Flags 0011, P=1.
- Base 0x1200, Off 0xFF -> 0x11FF, Flags 0000, P=2.
REQ-029 Subtract: Base 0x1000, Off 0x01, mode 10 -> 0x0FFF, Flags 0111, P=2; also mode 11 with Base 0x0001, Off 0x80 -> 0xFF81, Flags 0000 (same as mode 00).
REQ-030 Wide parameters (WIDTH=32, OFF_W=16): Base 0x0000FFFF, Off 0x0001, mode 01 -> 0x00010000, Flags 0011, P=3, o_Done at T+4, bits 31:24 untouched.
REQ-031 Handshake:
- i_Start held high during BYTE -> ignored; o_Result changes only at the first request's DONE.
- i_Start in the DONE cycle -> accepted back-to-back, o_Busy=1 in the next cycle.
REQ-032 Reset mid-operation: assert i_Reset in cycle T+1 of a P=2 request -> o_Busy, o_Done, o_Result and o_Flags all 0 immediately, no o_Done pulse afterwards, and a new request is accepted after release.
